mem_port_arbiter: RTL and testbench

Shares one external single-port memory between the pipelined datapath's instruction fetch (PCF) and its M-stage data access (ALUOutM/WriteDataM).
- Sequences at most one data access and then one instruction fetch per pipeline advance.
- Returns the results on ImmRD/DmmRD.
- Drives a global mem_stall. Top level ORs mem_stall into StallF/StallD and into the E/M/W register enables.
- Has a timeout watchdog on the memory handshake.

---
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: one data access then one fetch per pipeline advance, with handshake watchdog.
// Define MEM_PORT_ARB_PERF_EN to add stall/access performance counters.
module mem_port_arbiter #(
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [AW-1:0] PCF,
    input  logic [AW-1:0] ALUOutM,
    input  logic [DW-1:0] WriteDataM,
    input  logic          MemWriteM,
    input  logic          MemtoRegM,
    output logic [DW-1:0] ImmRD,
    output logic [DW-1:0] DmmRD,
    output logic          mem_stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
`ifdef MEM_PORT_ARB_PERF_EN
    output logic [31:0]   perf_stall_cycles,
    output logic [31:0]   perf_data_acc,
    output logic [31:0]   perf_fetch_acc,
`endif
    output logic          mem_err
);

    localparam int unsigned CNT_W    = 32;
    localparam logic [CNT_W-1:0] TMO_LAST = (TIMEOUT == 0) ? CNT_W'(0) : CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ARB     = 3'd0,
        D_ACC   = 3'd1,
        I_ACC   = 3'd2,
        RELEASE = 3'd3,
        ERR     = 3'd4
    } state_t;

    state_t           r_state;
    logic [DW-1:0]    r_imm_rd;
    logic [DW-1:0]    r_dmm_rd;
    logic             r_err;
    logic [CNT_W-1:0] r_tmo_cnt;

    logic w_d_need;
    logic w_is_load;
    logic w_tmo_hit;

    assign w_d_need  = MemWriteM | MemtoRegM;
    assign w_is_load = MemtoRegM & ~MemWriteM;  // a simultaneous store takes priority
    assign w_tmo_hit = (TIMEOUT != 0) && (r_tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ARB;
            r_imm_rd  <= '0;
            r_dmm_rd  <= '0;
            r_err     <= 1'b0;
            r_tmo_cnt <= '0;
        end else begin
            case (r_state)
                ARB: begin
                    r_tmo_cnt <= '0;
                    r_state   <= w_d_need ? D_ACC : I_ACC;
                end
                D_ACC: begin
                    if (mem_ack) begin
                        if (w_is_load) r_dmm_rd <= mem_rdata;
                        r_tmo_cnt <= '0;
                        r_state   <= I_ACC;
                    end else if (w_tmo_hit) begin
                        r_err     <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_state   <= ERR;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
                    end
                end
                I_ACC: begin
                    if (mem_ack) begin
                        r_imm_rd  <= mem_rdata;
                        r_tmo_cnt <= '0;
                        r_state   <= RELEASE;
                    end else if (w_tmo_hit) begin
                        r_err     <= 1'b1;
                        r_tmo_cnt <= '0;
                        r_state   <= ERR;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    r_tmo_cnt <= '0;
                    r_state   <= ARB;
                end
                ERR: begin
                    r_state <= ERR;
                end
                default: begin
                    r_tmo_cnt <= '0;
                    r_state   <= ARB;
                end
            endcase
        end
    end

    // Memory-side outputs follow the frozen pipeline inputs combinationally from state.
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (r_state)
            D_ACC: begin
                mem_req   = 1'b1;
                mem_we    = MemWriteM;
                mem_addr  = ALUOutM;
                mem_wdata = WriteDataM;
            end
            I_ACC: begin
                mem_req  = 1'b1;
                mem_addr = PCF;
            end
            default: begin
                mem_req = 1'b0;
            end
        endcase
    end

    assign mem_stall = (r_state != RELEASE);
    assign ImmRD     = r_imm_rd;
    assign DmmRD     = r_dmm_rd;
    assign mem_err   = r_err;

`ifdef MEM_PORT_ARB_PERF_EN
    logic [31:0] r_perf_stall;
    logic [31:0] r_perf_data;
    logic [31:0] r_perf_fetch;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_stall <= '0;
            r_perf_data  <= '0;
            r_perf_fetch <= '0;
        end else begin
            if (mem_stall) r_perf_stall <= r_perf_stall + 32'd1;
            if ((r_state == D_ACC) && mem_ack) r_perf_data <= r_perf_data + 32'd1;
            if ((r_state == I_ACC) && mem_ack) r_perf_fetch <= r_perf_fetch + 32'd1;
        end
    end

    assign perf_stall_cycles = r_perf_stall;
    assign perf_data_acc     = r_perf_data;
    assign perf_fetch_acc    = r_perf_fetch;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT=8 instance).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] PCF = '0;
    logic [31:0] ALUOutM = '0;
    logic [31:0] WriteDataM = '0;
    logic        MemWriteM = 1'b0;
    logic        MemtoRegM = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        ack_tie = 1'b1;
    logic        ack_man = 1'b0;

    logic [31:0] ImmRD, DmmRD, mem_addr, mem_wdata;
    logic        mem_stall, mem_req, mem_we, mem_err, mem_ack;
`ifdef MEM_PORT_ARB_PERF_EN
    logic [31:0] perf_stall_cycles, perf_data_acc, perf_fetch_acc;
`endif

    int checks = 0;
    int errors = 0;

    assign mem_ack = ack_tie ? mem_req : ack_man;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .PCF        (PCF),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .MemWriteM  (MemWriteM),
        .MemtoRegM  (MemtoRegM),
        .ImmRD      (ImmRD),
        .DmmRD      (DmmRD),
        .mem_stall  (mem_stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
`ifdef MEM_PORT_ARB_PERF_EN
        .perf_stall_cycles (perf_stall_cycles),
        .perf_data_acc     (perf_data_acc),
        .perf_fetch_acc    (perf_fetch_acc),
`endif
        .mem_err    (mem_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", mem_req); end
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b exp 1", mem_stall); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h exp 0", mem_addr); end
        checks++; if ({ImmRD, DmmRD} !== 64'h0) begin errors++; $display("FAIL reset_rd: got %h/%h exp 0/0", ImmRD, DmmRD); end
        checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", mem_err); end
        step();
        reset = 1'b1;
    endtask

    // Fetch-only loop: ARB, I_ACC, RELEASE repeating every 3 cycles.
    task automatic test_fetch_only();
        mem_rdata = 32'h20080005;
        #1;
        checks++; if ({mem_req, mem_stall} !== 2'b01) begin errors++; $display("FAIL f1_arb: req/stall got %b exp 01", {mem_req, mem_stall}); end
        step();
        checks++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h0}) begin errors++; $display("FAIL f1_iacc: got req=%b we=%b addr=%h exp 1 0 0", mem_req, mem_we, mem_addr); end
        step();
        checks++; if ({mem_stall, mem_req} !== 2'b00) begin errors++; $display("FAIL f1_rel: stall/req got %b exp 00", {mem_stall, mem_req}); end
        checks++; if (ImmRD !== 32'h20080005) begin errors++; $display("FAIL f1_imm: got %h exp 20080005", ImmRD); end
        step();
        PCF = 32'h4;
        mem_rdata = 32'h11112222;
        checks++; if ({mem_req, mem_stall} !== 2'b01) begin errors++; $display("FAIL f2_arb: req/stall got %b exp 01", {mem_req, mem_stall}); end
        step();
        checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h4}) begin errors++; $display("FAIL f2_iacc: got req=%b addr=%h exp 1 4", mem_req, mem_addr); end
        step();
        checks++; if ({mem_stall, ImmRD} !== {1'b0, 32'h11112222}) begin errors++; $display("FAIL f2_rel: got stall=%b imm=%h exp 0 11112222", mem_stall, ImmRD); end
    endtask

    // Store followed back-to-back by fetch; ends in RELEASE.
    task automatic test_store();
        MemWriteM = 1'b1; ALUOutM = 32'h100; WriteDataM = 32'hDEADBEEF; PCF = 32'h8; mem_rdata = 32'hCAFE0001;
        step();
        checks++; if ({mem_stall, mem_req} !== 2'b10) begin errors++; $display("FAIL st_arb: stall/req got %b exp 10", {mem_stall, mem_req}); end
        step();
        checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h100, 32'hDEADBEEF}) begin errors++; $display("FAIL st_dacc: got req=%b we=%b addr=%h wdata=%h exp 1 1 100 deadbeef", mem_req, mem_we, mem_addr, mem_wdata); end
        step();
        checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {2'b10, 32'h8, 32'h0}) begin errors++; $display("FAIL st_iacc: got req=%b we=%b addr=%h wdata=%h exp 1 0 8 0", mem_req, mem_we, mem_addr, mem_wdata); end
        checks++; if (DmmRD !== 32'h0) begin errors++; $display("FAIL st_dmm_iacc: got %h exp 0", DmmRD); end
        step();
        checks++; if ({mem_stall, mem_req, ImmRD, DmmRD} !== {2'b00, 32'hCAFE0001, 32'h0}) begin errors++; $display("FAIL st_rel: got stall=%b req=%b imm=%h dmm=%h exp 0 0 cafe0001 0", mem_stall, mem_req, ImmRD, DmmRD); end
    endtask

    // Load with ack in the third D_ACC cycle; starts in RELEASE.
    task automatic test_load_delayed();
        MemWriteM = 1'b0; MemtoRegM = 1'b1; ALUOutM = 32'h40; mem_rdata = 32'h12345678;
        ack_tie = 1'b0; ack_man = 1'b0;
        step();
        checks++; if (mem_stall !== 1'b1) begin errors++; $display("FAIL ld_single_release: stall got %b exp 1", mem_stall); end
        for (int k = 1; k <= 3; k++) begin
            step();
            checks++; if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h40}) begin errors++; $display("FAIL ld_dacc_c%0d: got req=%b we=%b addr=%h exp 1 0 40", k, mem_req, mem_we, mem_addr); end
            checks++; if (DmmRD !== 32'h0) begin errors++; $display("FAIL ld_dmm_early_c%0d: got %h exp 0", k, DmmRD); end
        end
        ack_man = 1'b1;
        step();
        ack_tie = 1'b1;
        mem_rdata = 32'h0BADF00D;
        checks++; if ({DmmRD, mem_addr} !== {32'h12345678, 32'h8}) begin errors++; $display("FAIL ld_to_iacc: got dmm=%h addr=%h exp 12345678 8", DmmRD, mem_addr); end
        step();
        MemtoRegM = 1'b0;
        checks++; if ({mem_stall, DmmRD, ImmRD} !== {1'b0, 32'h12345678, 32'h0BADF00D}) begin errors++; $display("FAIL ld_rel: got stall=%b dmm=%h imm=%h exp 0 12345678 0badf00d", mem_stall, DmmRD, ImmRD); end
    endtask

    // No ack ever: error after the 8th I_ACC cycle; starts in RELEASE.
    task automatic test_timeout();
        ack_tie = 1'b0; ack_man = 1'b0; PCF = 32'hC;
        step();
        step();
        for (int k = 1; k <= 7; k++) begin
            checks++; if ({mem_req, mem_err, mem_addr} !== {2'b10, 32'hC}) begin errors++; $display("FAIL to_wait_c%0d: got req=%b err=%b addr=%h exp 1 0 c", k, mem_req, mem_err, mem_addr); end
            step();
        end
        checks++; if ({mem_req, mem_err} !== 2'b10) begin errors++; $display("FAIL to_c8: got req=%b err=%b exp 1 0", mem_req, mem_err); end
        step();
        checks++; if ({mem_err, mem_req, mem_stall} !== 3'b101) begin errors++; $display("FAIL to_err: got err=%b req=%b stall=%b exp 1 0 1", mem_err, mem_req, mem_stall); end
        ack_man = 1'b1; mem_rdata = 32'hFFFFFFFF;
        step(); step(); step();
        checks++; if ({mem_err, mem_req, mem_stall, ImmRD} !== {3'b101, 32'h0BADF00D}) begin errors++; $display("FAIL to_late_ack: got err=%b req=%b stall=%b imm=%h exp 1 0 1 0badf00d", mem_err, mem_req, mem_stall, ImmRD); end
        ack_man = 1'b0;
        reset = 1'b0;
        #1;
        checks++; if ({mem_err, mem_stall, ImmRD} !== {2'b01, 32'h0}) begin errors++; $display("FAIL to_reset_clear: got err=%b stall=%b imm=%h exp 0 1 0", mem_err, mem_stall, ImmRD); end
        step();
        reset = 1'b1;
    endtask

    // Reset mid D_ACC drops the request at once and captures nothing.
    task automatic test_reset_mid_access();
        MemtoRegM = 1'b1; ALUOutM = 32'h80; mem_rdata = 32'h55555555; ack_tie = 1'b0; ack_man = 1'b0;
        step();
        checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h80}) begin errors++; $display("FAIL rm_dacc: got req=%b addr=%h exp 1 80", mem_req, mem_addr); end
        ack_man = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        checks++; if ({mem_req, mem_stall} !== 2'b01) begin errors++; $display("FAIL rm_async: got req=%b stall=%b exp 0 1", mem_req, mem_stall); end
        step();
        checks++; if (DmmRD !== 32'h0) begin errors++; $display("FAIL rm_no_capture: got %h exp 0", DmmRD); end
        ack_man = 1'b0; ack_tie = 1'b1;
        reset = 1'b1;
        #1;
        checks++; if ({mem_req, mem_stall} !== 2'b01) begin errors++; $display("FAIL rm_arb: got req=%b stall=%b exp 0 1", mem_req, mem_stall); end
        step();
        checks++; if ({mem_req, mem_addr} !== {1'b1, 32'h80}) begin errors++; $display("FAIL rm_restart: got req=%b addr=%h exp 1 80", mem_req, mem_addr); end
        step();
        checks++; if (DmmRD !== 32'h55555555) begin errors++; $display("FAIL rm_load: got %h exp 55555555", DmmRD); end
        step();
        MemtoRegM = 1'b0;
    endtask

`ifdef MEM_PORT_ARB_PERF_EN
    task automatic test_perf();
        reset = 1'b0;
        step();
        reset = 1'b1;
        MemWriteM = 1'b1; ALUOutM = 32'h100; WriteDataM = 32'hDEADBEEF; PCF = 32'h8; ack_tie = 1'b1;
        #1;
        checks++; if ({perf_stall_cycles, perf_data_acc, perf_fetch_acc} !== 96'h0) begin errors++; $display("FAIL perf_reset: got %0d %0d %0d exp 0 0 0", perf_stall_cycles, perf_data_acc, perf_fetch_acc); end
        for (int k = 0; k < 7; k++) step();
        checks++; if (mem_stall !== 1'b0) begin errors++; $display("FAIL perf_rel: stall got %b exp 0", mem_stall); end
        checks++; if ({perf_stall_cycles, perf_data_acc, perf_fetch_acc} !== {32'd6, 32'd2, 32'd2}) begin errors++; $display("FAIL perf_counts: got %0d %0d %0d exp 6 2 2", perf_stall_cycles, perf_data_acc, perf_fetch_acc); end
        MemWriteM = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL global_timeout: bench exceeded time limit");
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_fetch_only();
        test_store();
        test_load_delayed();
        test_timeout();
        test_reset_mid_access();
`ifdef MEM_PORT_ARB_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
